sr_flag_arbiter: RTL

Round-robin command arbiter that shares one falling-edge SR flip-flop (a single shared status flag) among `NREQ` requesters. It serialises set/clear requests and drives the flop's `S`/`R` inputs, never asserting both together. After each command it reads `Q` back, re-drives it on a mismatch, and returns an acknowledge to the requester. It sits between the requester logic (rising-edge domain) and the `S`/`R`/`Q` pins of the falling-edge SR flop, on the same `clk`.

---
 rtl/sr_flag_arbiter_pkg.sv | 14 +
 rtl/sr_flag_arbiter_rr_picker.sv | 30 +++
 rtl/sr_flag_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/sr_flag_arbiter_pkg.sv
// Shared definitions for the SR flag arbiter: FSM state encodings and op codes.
package sr_flag_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OP_CLEAR = 1'b0;
  localparam logic OP_SET   = 1'b1;

endpackage

// File: rtl/sr_flag_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first active request at or after ptr.
module rr_picker
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the closest match to ptr is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising set/clear commands onto one shared falling-edge
// SR flop, with Q read-back, bounded re-drive and per-requester acknowledge.
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  output logic [NREQ-1:0] ack,
  output logic            err,
  output logic            fault,
  output logic            busy,
  output logic            S,
  output logic            R,
  input  logic            q_in
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic          expv;
  logic [2:0]    retry;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req       (req),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // S and R are only ever loaded as complements in the DRIVE entry, so they can never both be 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      retry <= '0;
      S     <= 1'b0;
      R     <= 1'b0;
      ack   <= '0;
      err   <= 1'b0;
      fault <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            winner <= gnt_idx;
            expv   <= op[gnt_idx];
            retry  <= '0;
            S      <= (op[gnt_idx] == OP_SET);
            R      <= (op[gnt_idx] == OP_CLEAR);
            busy   <= 1'b1;
            state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          S     <= 1'b0;
          R     <= 1'b0;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (q_in == expv) begin
            ack   <= onehot(winner);
            state <= ST_RESP;
          end else if (int'(retry) < MAX_RETRY) begin
            retry <= retry + 3'd1;
            S     <= expv;
            R     <= ~expv;
            state <= ST_DRIVE;
          end else begin
            ack   <= onehot(winner);
            err   <= 1'b1;
            fault <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          ptr   <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
